// File: rtl/lb_pkg.sv
// Shared defaults and width helper for the line buffer ring.
package lb_pkg;

    localparam int LB_DATA_W    = 24;
    localparam int LB_LINE_LEN  = 800;
    localparam int LB_NUM_LINES = 4;

    function automatic int lb_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lb_ram.sv
// Single-clock simple dual-port RAM holding NUM_LINES lines of LINE_LEN pixels.
// Registered read port: data appears one cycle after rd_en and holds otherwise.
module lb_ram
    import lb_pkg::*;
#(
    parameter int DATA_W    = LB_DATA_W,
    parameter int LINE_LEN  = LB_LINE_LEN,
    parameter int NUM_LINES = LB_NUM_LINES,
    parameter int CW        = lb_clog2(LINE_LEN),
    parameter int LW        = lb_clog2(NUM_LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [LW-1:0]     wr_line,
    input  logic [CW-1:0]     wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [LW-1:0]     rd_line,
    input  logic [CW-1:0]     rd_col,
    output logic [DATA_W-1:0] rd_data
);

    localparam int  DEPTH = NUM_LINES * LINE_LEN;
    localparam int  AW    = lb_clog2(DEPTH);
    localparam bit  POW2  = ((LINE_LEN & (LINE_LEN - 1)) == 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;

    // Power-of-two lines pack as {line, col}; otherwise a true multiply is needed.
    generate
        if (POW2) begin : g_concat
            assign wr_addr = {wr_line, wr_col};
            assign rd_addr = {rd_line, rd_col};
        end else begin : g_mult
            assign wr_addr = AW'(wr_line) * AW'(LINE_LEN) + AW'(wr_col);
            assign rd_addr = AW'(rd_line) * AW'(LINE_LEN) + AW'(rd_col);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_buffer_ring.sv
// N-line ring of line buffers: streaming writer commits whole lines, random-access
// reader retires them explicitly. Optional underrun counter: LB_UNDERRUN_CNT_EN.
module line_buffer_ring
    import lb_pkg::*;
#(
    parameter int DATA_W    = LB_DATA_W,
    parameter int LINE_LEN  = LB_LINE_LEN,
    parameter int NUM_LINES = LB_NUM_LINES,
    parameter int ADDR_W    = lb_clog2(LINE_LEN),
    parameter int LVL_W     = lb_clog2(NUM_LINES + 1)
) (
    input  logic              clk_pixel,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_line_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_line_valid,
    input  logic              rd_release,
    output logic [LVL_W-1:0]  level,
    output logic [15:0]       underrun_cnt
);

    localparam int LW = lb_clog2(NUM_LINES);

    logic [LW-1:0]     wr_line;
    logic [LW-1:0]     rd_line;
    logic [ADDR_W-1:0] wr_col;
    logic              accept;
    logic              commit;
    logic              retire;

    function automatic logic [LW-1:0] next_line(input logic [LW-1:0] line);
        return (line == LW'(NUM_LINES - 1)) ? '0 : line + LW'(1);
    endfunction

    assign wr_ready      = (level != LVL_W'(NUM_LINES));
    assign rd_line_valid = (level != '0);

    // A beat offered during flush is dropped, so it never reaches the RAM.
    assign accept = wr_valid && wr_ready && !flush;
    assign commit = accept && (wr_col == ADDR_W'(LINE_LEN - 1));
    assign retire = rd_release && rd_line_valid && !flush;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            wr_line       <= '0;
            wr_col        <= '0;
            rd_line       <= '0;
            level         <= '0;
            wr_line_done  <= 1'b0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= rd_en;
            if (flush) begin
                wr_line      <= '0;
                wr_col       <= '0;
                rd_line      <= '0;
                level        <= '0;
                wr_line_done <= 1'b0;
            end else begin
                wr_line_done <= commit;
                if (accept) begin
                    wr_col <= commit ? '0 : wr_col + ADDR_W'(1);
                end
                if (commit) begin
                    wr_line <= next_line(wr_line);
                end
                if (retire) begin
                    rd_line <= next_line(rd_line);
                end
                if (commit && !retire) begin
                    level <= level + LVL_W'(1);
                end else if (retire && !commit) begin
                    level <= level - LVL_W'(1);
                end
            end
        end
    end

`ifdef LB_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            underrun_q <= 16'd0;
        end else if (rd_en && !rd_line_valid) begin
            underrun_q <= sat_inc16(underrun_q);
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = 16'd0;
`endif

    lb_ram #(
        .DATA_W    (DATA_W),
        .LINE_LEN  (LINE_LEN),
        .NUM_LINES (NUM_LINES),
        .CW        (ADDR_W),
        .LW        (LW)
    ) u_ram (
        .clk     (clk_pixel),
        .rst     (rst),
        .wr_en   (accept),
        .wr_line (wr_line),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_line (rd_line),
        .rd_col  (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_line_buffer_ring.sv
// Scoreboard bench for line_buffer_ring: a queue-of-lines reference model predicts
// every read and handshake; a monitor checks read data as the DUT presents it.
module tb_line_buffer_ring;

    localparam int DW = 24;
    localparam int LL = 8;
    localparam int NL = 4;

    typedef logic [DW-1:0] line_t [LL];
    typedef struct {
        bit            chk;
        logic [DW-1:0] d;
    } rd_t;

    logic          clk_pixel = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_line_done;
    logic          rd_en;
    logic [2:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;
    logic          rd_line_valid;
    logic          rd_release;
    logic [2:0]    level;
    logic [15:0]   underrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    line_t         lines[$];
    logic [DW-1:0] partial[$];
    rd_t           sbq[$];
    bit            done_exp = 1'b0;
    int unsigned   und_exp  = 0;
    bit            hold_ok  = 1'b0;
    logic [DW-1:0] hold_d   = '0;

    line_buffer_ring #(
        .DATA_W    (DW),
        .LINE_LEN  (LL),
        .NUM_LINES (NL)
    ) dut (
        .clk_pixel     (clk_pixel),
        .rst           (rst),
        .flush         (flush),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .wr_line_done  (wr_line_done),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .rd_line_valid (rd_line_valid),
        .rd_release    (rd_release),
        .level         (level),
        .underrun_cnt  (underrun_cnt)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check state, drive inputs, predict, advance the model past the edge.
    task automatic cycle(input bit fl, input bit wv, input logic [DW-1:0] wd,
                         input bit re, input int ra, input bit rel);
        int pre;
        bit acc;
        check("level", 32'(level), 32'(lines.size()));
        check("wr_ready", 32'(wr_ready), 32'(lines.size() != NL));
        check("rd_line_valid", 32'(rd_line_valid), 32'(lines.size() != 0));
        check("wr_line_done", 32'(wr_line_done), 32'(done_exp));
        check("underrun_cnt", 32'(underrun_cnt), und_exp);

        flush      = fl;
        wr_valid   = wv;
        wr_data    = wd;
        rd_en      = re;
        rd_addr    = 3'(ra);
        rd_release = rel;

        pre = lines.size();
        acc = wv && (pre != NL) && !fl;
        if (re) begin
            if (pre > 0) begin
                sbq.push_back('{1'b1, lines[0][ra]});
            end else begin
                sbq.push_back('{1'b0, '0});
`ifdef LB_UNDERRUN_CNT_EN
                if (und_exp < 32'hFFFF) und_exp++;
`endif
            end
        end

        @(posedge clk_pixel);
        #1;
        done_exp = 1'b0;
        if (fl) begin
            lines.delete();
            partial.delete();
        end else begin
            if (rel && pre > 0) void'(lines.pop_front());
            if (acc) begin
                partial.push_back(wd);
                if (partial.size() == LL) begin
                    line_t t;
                    for (int i = 0; i < LL; i++) t[i] = partial[i];
                    lines.push_back(t);
                    partial.delete();
                    done_exp = 1'b1;
                end
            end
        end
        flush      = 1'b0;
        wr_valid   = 1'b0;
        rd_en      = 1'b0;
        rd_release = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, 0, 0);
    endtask

    task automatic write_rand_line();
        int k;
        k = 0;
        while (k < LL) begin
            if ($urandom_range(3) != 0) begin
                cycle(0, 1, DW'($urandom), 0, 0, 0);
                k++;
            end else begin
                idle(1);
            end
        end
    endtask

    task automatic read_head();
        for (int a = 0; a < LL; a++) cycle(0, 0, '0, 1, a, 0);
    endtask

    // Read-data monitor, decoupled from stimulus.
    always @(negedge clk_pixel) begin
        if (!rst) begin
            if (rd_data_valid) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got rd_data_valid=1 required 0 at %0t", $time);
                end else begin
                    rd_t e;
                    e = sbq.pop_front();
                    if (e.chk) begin
                        check("rd_data", 32'(rd_data), 32'(e.d));
                        hold_d  = e.d;
                        hold_ok = 1'b1;
                    end else begin
                        hold_ok = 1'b0;
                    end
                end
            end else if (hold_ok) begin
                check("rd_hold", 32'(rd_data), 32'(hold_d));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        repeat (3) @(posedge clk_pixel);
        #1;
        rst = 1'b0;
        check("rst_level", 32'(level), 0);
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_rd_line_valid", 32'(rd_line_valid), 0);
        check("rst_rd_data_valid", 32'(rd_data_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_wr_line_done", 32'(wr_line_done), 0);
        check("rst_underrun", 32'(underrun_cnt), 0);
        hold_ok = 1'b1;
        hold_d  = '0;

        // Basic line 0..7 then read it back
        for (int i = 0; i < LL; i++) cycle(0, 1, DW'(i), 0, 0, 0);
        check("basic_done", 32'(wr_line_done), 1);
        check("basic_level", 32'(level), 1);
        read_head();

        // Fill to full, offer AA while full, then release one
        for (int l = 0; l < 3; l++) write_rand_line();
        check("full_ready", 32'(wr_ready), 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, DW'('hAA), 0, 0, 0);
        read_head();
        cycle(0, 0, '0, 0, 0, 1);
        check("full_rel_ready", 32'(wr_ready), 1);
        check("full_rel_level", 32'(level), 3);

        // Simultaneous commit and release at level 2
        cycle(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < LL - 1; i++) cycle(0, 1, DW'(100 + i), 0, 0, 0);
        cycle(0, 1, DW'(107), 1, 3, 1);
        check("sim_level", 32'(level), 2);
        read_head();

        // Wrap-around through ten lines
        cycle(1, 0, '0, 0, 0, 0);
        for (int l = 0; l < 10; l++) begin
            write_rand_line();
            for (int i = 0; i < LL; i++) cycle(0, 0, '0, 1, int'($urandom_range(LL - 1)), 0);
            read_head();
            cycle(0, 0, '0, 1, l % LL, 1);
        end

        // Flush mid-line with a beat in the flush cycle
        for (int i = 0; i < 5; i++) cycle(0, 1, DW'(200 + i), 0, 0, 0);
        cycle(1, 1, DW'(205), 0, 0, 0);
        check("flush_level", 32'(level), 0);
        for (int i = 0; i < LL; i++) cycle(0, 1, DW'(300 + i), 0, 0, 0);
        read_head();
        cycle(0, 0, '0, 0, 0, 1);

        // Underrun reads and a release at level 0
        cycle(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1, i, 0);
        cycle(0, 0, '0, 0, 0, 1);
        idle(1);
        check("underrun_level", 32'(level), 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(63) == 0, $urandom_range(1) == 1, DW'($urandom),
                  $urandom_range(1) == 1, int'($urandom_range(LL - 1)),
                  $urandom_range(5) == 0);
        end

        idle(3);
        check("sb_drain", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_buffer_ring.md
Name: line_buffer_ring

Overview:
- Parametrised N-line ring of line buffers. Generalises the fixed two-buffer ping-pong scheme to NUM_LINES lines of LINE_LEN pixels at DATA_W bits each.
- A streaming writer fills whole lines under valid/ready flow control. A random-access reader consumes completed lines and releases each one explicitly.
- Sits between the frame fetcher and the pixel pipeline in the pixel clock domain. Supports line repeat and scaling, because the reader decides when a line is retired.

Parameters:
- DATA_W, 24, pixel width in bits.
- LINE_LEN, 800, pixels per line; must be at least 2.
- NUM_LINES, 4, lines in the ring; must be at least 2.
- ADDR_W, $clog2(LINE_LEN), column address width (derived).
- LVL_W, $clog2(NUM_LINES+1), occupancy width (derived).

Ports:
- clk_pixel  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pulse; discards all lines, e.g. at frame start.
- wr_valid  in  1  writer has a pixel.
- wr_data  in  DATA_W  pixel value.
- wr_ready  out  1  a free line exists; a beat is accepted when wr_valid and wr_ready are both high.
- wr_line_done  out  1  one-cycle pulse when a line is committed.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  column within the head line.
- rd_data  out  DATA_W  read data, one cycle after rd_en.
- rd_data_valid  out  1  rd_en delayed by one cycle.
- rd_line_valid  out  1  at least one committed line is present.
- rd_release  in  1  pulse; retires the head line.
- level  out  LVL_W  number of committed lines.
- underrun_cnt  out  16  see Optional Feature.

Behaviour:
- Reset (rst=1, synchronous): wr_line, wr_col, rd_line and level are 0; wr_ready=1; wr_line_done=0; rd_data_valid=0; rd_line_valid=0; rd_data=0; underrun_cnt=0. RAM contents are not cleared.
- Write side:
  - wr_ready = (level != NUM_LINES), purely combinational from level.
  - An accepted beat writes RAM[wr_line][wr_col]. wr_col then increments.
  - A beat accepted at wr_col == LINE_LEN-1 commits the line: wr_col wraps to 0, wr_line advances (wrapping NUM_LINES-1 to 0), level increments, and wr_line_done pulses in the next cycle.
  - A partial line is never visible to the reader.
- Read side:
  - rd_line_valid = (level != 0).
  - On rd_en, RAM[rd_line][rd_addr] appears on rd_data with exactly one cycle of latency; rd_data_valid mirrors that.
  - rd_data holds its last value while rd_en is low.
  - rd_addr >= LINE_LEN gives undefined data but must not corrupt state.
  - Reading while rd_line_valid=0 returns stale or undefined data, with no state change other than underrun counting.
- Release:
  - rd_release with level>0: rd_line advances (with wrap) and level decrements.
  - rd_release with level=0: ignored.
  - A read issued in the same cycle as a release uses the old rd_line.
- Simultaneous commit and release: level is unchanged; both pointers advance.
- Full: with level=NUM_LINES, wr_ready=0 and wr_valid is ignored. A release in that cycle raises wr_ready in the next cycle; there is no combinational ready-from-release path.
- Flush: has priority over commit and release in the same cycle. wr_col, wr_line, rd_line and level go to 0; a partial write line is discarded. The write beat presented in the flush cycle is dropped. underrun_cnt is not cleared.
- Reset or flush mid-line is legal; the writer restarts at column 0 of line 0.

Optional Feature:
- Macro: LB_UNDERRUN_CNT_EN.
- Defined:
  - underrun_cnt increments by one for every cycle with rd_en=1 and rd_line_valid=0.
  - It saturates at 16'hFFFF and is cleared only by rst.
- Undefined:
  - The counter logic is not built and underrun_cnt is tied to 16'd0.
  - The port remains so that instantiations do not change.

Decomposition:
- Package lb_pkg holds the default constants (LB_DATA_W=24, LB_LINE_LEN=800, LB_NUM_LINES=4) and a function lb_clog2 for the derived widths.
- One sub-module, lb_ram: simple dual-port RAM with a single clock, depth NUM_LINES*LINE_LEN, write port plus registered read port, and 1-cycle latency. The address is {line, col} when LINE_LEN is a power of two, otherwise line*LINE_LEN+col.
- Pointer, level and handshake logic live in line_buffer_ring.

Test Plan:
- Basic write and read: NUM_LINES=4, LINE_LEN=8. Write a line with pixel values 0..7. Expect wr_line_done to pulse one cycle after the 8th beat and level=1. Read addresses 0..7 and expect rd_data=0..7, each one cycle after its rd_en.
- Fill to full: commit 4 lines, expect wr_ready=0 and level=4. Hold wr_valid=1 with data AA for 5 cycles and expect no writes. Release one line; expect wr_ready=1 in the next cycle and level=3.
- Simultaneous commit and release with level=2: expect level to stay 2 and both pointers to advance. Reads after the release return the second line's data.
- Wrap-around: stream 10 lines, releasing each line after reading it. Expect each line's data intact, including lines 4 and 8, which reuse RAM slots 0.
- Flush mid-line: write 5 beats, then assert flush together with a 6th beat. Expect level=0, the next line to start at column 0, and the 6th beat to be absent.
- Underrun with LB_UNDERRUN_CNT_EN defined: 3 rd_en cycles at level=0 should give underrun_cnt=3. A release at level 0 leaves level at 0. Built without the macro, underrun_cnt=0.
